fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core. It owns the PC, fetches from instruction memory over a req/ready handshake, applies branch/jump redirects resolved in decode, honours hazard-unit stall/flush, and presents the decode-stage instruction whose op/funct fields drive the decode controller.

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core.
// Define FETCH_PERF_CNT_EN to build the delivered-instruction counter on fetch_count.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush_d,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {FETCH, KILL, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc_f, pc_n;
    logic [31:0] buf_instr, buf_instr_n;
    logic [31:0] buf_pc4, buf_pc4_n;
    logic [31:0] redir_pc, redir_pc_n;
    logic [31:0] pc_plus4, target;
    logic [31:0] load_instr, load_pc4;
    logic        redirect, ifid_load, ifid_bubble;

    assign redirect  = ~stall & (jmp | pc_src);
    assign target    = jmp ? jmp_target : branch_target;
    assign pc_plus4  = pc_f + 32'd4;
    assign imem_req  = rst_n & (state != HOLD);
    assign imem_addr = pc_f;

    always_comb begin
        state_n     = state;
        pc_n        = pc_f;
        buf_instr_n = buf_instr;
        buf_pc4_n   = buf_pc4;
        redir_pc_n  = redir_pc;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        load_instr  = imem_rdata;
        load_pc4    = pc_plus4;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_n        = target;
                        ifid_bubble = 1'b1;
                    end else if (stall) begin
                        // Word arrived while decode is frozen: park it so the request can drop.
                        buf_instr_n = imem_rdata;
                        buf_pc4_n   = pc_plus4;
                        pc_n        = pc_plus4;
                        state_n     = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_n      = pc_plus4;
                    end
                end else if (redirect) begin
                    redir_pc_n  = target;
                    ifid_bubble = 1'b1;
                    state_n     = KILL;
                end else begin
                    ifid_bubble = ~stall;
                end
            end
            KILL: begin
                // The outstanding request cannot be withdrawn; its word is dropped on arrival.
                if (redirect)
                    redir_pc_n = target;
                if (imem_ready) begin
                    pc_n    = redirect ? target : redir_pc;
                    state_n = FETCH;
                end
                ifid_bubble = ~stall;
            end
            HOLD: begin
                if (!stall) begin
                    state_n = FETCH;
                    if (redirect) begin
                        pc_n        = target;
                        ifid_bubble = 1'b1;
                    end else begin
                        ifid_load  = 1'b1;
                        load_instr = buf_instr;
                        load_pc4   = buf_pc4;
                    end
                end
            end
            default: state_n = FETCH;
        endcase
        if (flush_d) begin
            ifid_load   = 1'b0;
            ifid_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc_f       <= RESET_PC;
            buf_instr  <= '0;
            buf_pc4    <= '0;
            redir_pc   <= '0;
            instr_d    <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else begin
            state     <= state_n;
            pc_f      <= pc_n;
            buf_instr <= buf_instr_n;
            buf_pc4   <= buf_pc4_n;
            redir_pc  <= redir_pc_n;
            if (ifid_load) begin
                instr_d    <= load_instr;
                pc_plus4_d <= load_pc4;
                valid_d    <= 1'b1;
            end else if (ifid_bubble) begin
                instr_d <= '0;
                valid_d <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            fetch_count <= '0;
        else if (ifid_load)
            fetch_count <= fetch_count + 32'd1;
    end
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus scoreboard of delivered instructions,
// then reset-during-HOLD and PC wrap-around sequences on a second instance.
module tb_fetch_stage;

    typedef struct {
        logic        rdy, st, fl, pcs, jm;
        logic [31:0] bt, jt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid, push, pop;
    } vec_t;

    typedef struct {
        logic [31:0] instr, pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        stall, flush_d, pc_src, jmp, imem_ready;
    logic [31:0] branch_target, jmp_target;
    logic        imem_req, valid_d, imem_req2, valid_d2;
    logic [31:0] imem_addr, imem_rdata, instr_d, pc_plus4_d, fetch_count;
    logic [31:0] imem_addr2, imem_rdata2, instr_d2, pc_plus4_d2, fetch_count2;

    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    exp_t sb[$];
    exp_t held;
    vec_t vecs[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata2 = mem_word(imem_addr2);

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush_d(flush_d),
        .pc_src(pc_src), .branch_target(branch_target), .jmp(jmp), .jmp_target(jmp_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst2_n), .stall(stall), .flush_d(flush_d),
        .pc_src(pc_src), .branch_target(branch_target), .jmp(jmp), .jmp_target(jmp_target),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .imem_ready(imem_ready),
        .instr_d(instr_d2), .pc_plus4_d(pc_plus4_d2), .valid_d(valid_d2), .fetch_count(fetch_count2)
    );

    function automatic vec_t mk(input logic rdy, st, fl, pcs, jm, input logic [31:0] bt, jt,
                                input logic req, input logic [31:0] addr, input logic vld, psh, pp);
        vec_t v;
        v.rdy = rdy; v.st = st; v.fl = fl; v.pcs = pcs; v.jm = jm; v.bt = bt; v.jt = jt;
        v.exp_req = req; v.exp_addr = addr; v.exp_valid = vld; v.push = psh; v.pop = pp;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        imem_ready    = v.rdy;
        stall         = v.st;
        flush_d       = v.fl;
        pc_src        = v.pcs;
        jmp           = v.jm;
        branch_target = v.bt;
        jmp_target    = v.jt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic popCheck(input string tag);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s_sb_empty: got 0 entries expected 1", tag);
        end else begin
            held = sb.pop_front();
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        held = '{instr: 32'h0, pc4: 32'h0};
        rst_n = 1'b0;
        rst2_n = 1'b0;
        applyStimulus(mk(0,0,0,0,0,0,0,0,0,0,0,0));

        //        rdy st fl pcs jm  bt        jt         req addr       vld psh pop
        vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,     1, 32'h000, 0,1,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,     1, 32'h004, 1,1,1));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,     1, 32'h008, 1,0,1));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,     1, 32'h008, 0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,     1, 32'h008, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,     1, 32'h008, 0,1,0));
        vecs.push_back(mk(1,0,0,1,1, 32'h200,  32'h100,   1, 32'h00C, 1,0,1));
        vecs.push_back(mk(0,0,0,1,0, 32'h40,   32'h0,     1, 32'h100, 0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,     1, 32'h100, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,     1, 32'h100, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,     1, 32'h040, 0,1,0));
        vecs.push_back(mk(1,1,0,0,0, 32'h0,    32'h0,     1, 32'h044, 1,1,1));
        vecs.push_back(mk(1,1,0,0,0, 32'h0,    32'h0,     0, 32'h048, 1,0,0));
        vecs.push_back(mk(0,1,1,0,0, 32'h0,    32'h0,     0, 32'h048, 1,0,0));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,     0, 32'h048, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,     1, 32'h048, 1,1,1));
        vecs.push_back(mk(1,1,0,0,0, 32'h0,    32'h0,     1, 32'h04C, 1,0,1));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h80,    0, 32'h050, 1,0,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,     1, 32'h080, 0,1,0));
        vecs.push_back(mk(1,1,0,1,0, 32'h300,  32'h0,     1, 32'h084, 1,1,1));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,     0, 32'h088, 1,0,0));
        vecs.push_back(mk(1,0,1,0,0, 32'h0,    32'h0,     1, 32'h088, 1,0,1));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,     1, 32'h08C, 0,1,0));
        vecs.push_back(mk(0,0,0,1,0, 32'h500,  32'h0,     1, 32'h090, 1,0,1));
        vecs.push_back(mk(0,0,0,0,1, 32'h0,    32'h600,   1, 32'h090, 0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 32'h0,    32'h0,     1, 32'h090, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,     1, 32'h600, 0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,     1, 32'h604, 1,0,1));
        vecs.push_back(mk(0,0,0,1,0, 32'h700,  32'h0,     1, 32'h604, 0,0,0));
        vecs.push_back(mk(1,0,0,0,1, 32'h0,    32'h800,   1, 32'h604, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,     1, 32'h800, 0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,     1, 32'h804, 1,0,1));

        // Reset state after one clock edge with rst_n low.
        nextCycle();
        @(negedge clk);
        checkOutput("rst_req", imem_req, 0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_valid", valid_d, 0);
        checkOutput("rst_instr", instr_d, 32'h0);
        checkOutput("rst_pc4", pc_plus4_d, 32'h0);
        checkOutput("rst_cnt", fetch_count, 32'h0);
        checkOutput("rst_wrap_req", imem_req2, 0);

        nextCycle();
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0)
                nextCycle();
            applyStimulus(vecs[i]);
            if (vecs[i].push)
                sb.push_back('{instr: mem_word(vecs[i].exp_addr), pc4: vecs[i].exp_addr + 32'd4});
            @(negedge clk);
            if (vecs[i].pop) begin
                popCheck($sformatf("v%0d", i));
`ifdef FETCH_PERF_CNT_EN
                exp_cnt++;
`endif
            end
            checkOutput($sformatf("v%0d_req", i), imem_req, vecs[i].exp_req);
            checkOutput($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            checkOutput($sformatf("v%0d_valid", i), valid_d, vecs[i].exp_valid);
            checkOutput($sformatf("v%0d_instr", i), instr_d, vecs[i].exp_valid ? held.instr : 32'h0);
            checkOutput($sformatf("v%0d_pc4", i), pc_plus4_d, held.pc4);
            checkOutput($sformatf("v%0d_cnt", i), fetch_count, exp_cnt);
        end
        checkOutput("sb_drained", sb.size(), 0);

        // Reset while parked in HOLD: buffered word is lost, fetch restarts at RESET_PC.
        nextCycle();
        applyStimulus(mk(1,1,0,0,0,0,0,0,0,0,0,0));
        nextCycle();
        @(negedge clk);
        checkOutput("hold_req", imem_req, 0);
        checkOutput("hold_addr", imem_addr, 32'h808);
        nextCycle();
        rst_n = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("hrst_req", imem_req, 0);
        checkOutput("hrst_addr", imem_addr, 32'h0);
        checkOutput("hrst_valid", valid_d, 0);
        checkOutput("hrst_cnt", fetch_count, 32'h0);
        exp_cnt = 0;
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(mk(1,0,0,0,0,0,0,0,0,0,0,0));
        sb.push_back('{instr: mem_word(32'h0), pc4: 32'h4});
        @(negedge clk);
        checkOutput("hrel_req", imem_req, 1);
        checkOutput("hrel_addr", imem_addr, 32'h0);
        nextCycle();
        @(negedge clk);
        popCheck("hrel");
`ifdef FETCH_PERF_CNT_EN
        exp_cnt = 1;
`endif
        checkOutput("hrel_valid", valid_d, 1);
        checkOutput("hrel_instr", instr_d, held.instr);
        checkOutput("hrel_pc4", pc_plus4_d, held.pc4);
        checkOutput("hrel_cnt", fetch_count, exp_cnt);

        // PC wrap-around on the instance reset to 0xFFFF_FFF8.
        exp_cnt = 0;
        nextCycle();
        rst2_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            logic [31:0] a;
            a = 32'hFFFF_FFF8 + 32'(c * 4);
            if (c != 0)
                nextCycle();
            sb.push_back('{instr: mem_word(a), pc4: a + 32'd4});
            @(negedge clk);
            checkOutput($sformatf("wrap%0d_addr", c), imem_addr2, a);
            checkOutput($sformatf("wrap%0d_valid", c), valid_d2, (c != 0) ? 32'd1 : 32'd0);
            if (c != 0) begin
                popCheck($sformatf("wrap%0d", c));
`ifdef FETCH_PERF_CNT_EN
                exp_cnt++;
`endif
                checkOutput($sformatf("wrap%0d_instr", c), instr_d2, held.instr);
                checkOutput($sformatf("wrap%0d_pc4", c), pc_plus4_d2, held.pc4);
            end
        end
        checkOutput("wrap_cnt", fetch_count2, exp_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
